// File: rtl/riscv_bram_arbiter_pkg.sv
// Shared types for the BRAM arbiter: FSM state encoding (ST_IDLE/ST_RMW)
// and requester identifiers (PORT_IF/PORT_D).
package riscv_bram_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RMW  = 1'b1
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

endpackage

// File: rtl/riscv_bram_byte_merge.sv
// Combinational byte merge: each strobed byte is taken from new_word,
// every other byte is kept from old_word.
module riscv_bram_byte_merge #(
    parameter int WORD_LENGTH = 32
) (
    input  logic [WORD_LENGTH-1:0]   old_word,
    input  logic [WORD_LENGTH-1:0]   new_word,
    input  logic [WORD_LENGTH/8-1:0] wstrb,
    output logic [WORD_LENGTH-1:0]   merged
);

    // Select each byte lane independently from the strobe bit
    always_comb begin
        merged = old_word;
        for (int b = 0; b < WORD_LENGTH / 8; b++) begin
            if (wstrb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/riscv_bram_arbiter.sv
// Arbiter sharing one BRAM between the instruction-fetch (IF) and data (D)
// ports. Loads/fetches read in the accept cycle and return registered data
// one cycle later; full stores write directly; partial stores perform a
// read-modify-write through the ST_RMW state.
// Optional macro RISCV_BRAM_ARB_RR_EN: round-robin arbitration on contention
// (default build: fixed priority, D over IF).
//
// Handshake: a request transfers in a cycle where valid & ready are both 1;
// ready may depend combinationally on valid, and the requester holds valid,
// addr and data stable until ready. Responses are single-cycle valid pulses
// with no backpressure.
module riscv_bram_arbiter
    import riscv_bram_arbiter_pkg::*;
#(
    parameter int WORD_LENGTH = 32,
    parameter int ADDR_LENGTH = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req_valid,
    output logic                     if_req_ready,
    input  logic [ADDR_LENGTH-1:0]   if_req_addr,
    output logic                     if_rsp_valid,
    output logic [WORD_LENGTH-1:0]   if_rsp_rdata,
    input  logic                     d_req_valid,
    output logic                     d_req_ready,
    input  logic [ADDR_LENGTH-1:0]   d_req_addr,
    input  logic                     d_req_we,
    input  logic [WORD_LENGTH/8-1:0] d_req_wstrb,
    input  logic [WORD_LENGTH-1:0]   d_req_wdata,
    output logic                     d_rsp_valid,
    output logic [WORD_LENGTH-1:0]   d_rsp_rdata,
    output logic                     bram_write_en,
    output logic [ADDR_LENGTH-1:0]   bram_waddr,
    output logic [WORD_LENGTH-1:0]   bram_wdata,
    output logic [ADDR_LENGTH-1:0]   bram_raddr,
    input  logic [WORD_LENGTH-1:0]   bram_dout
);

    localparam int STRB_W = WORD_LENGTH / 8;

    state_t                 state_q;
    state_t                 state_d;
    port_t                  winner;
    logic                   grant_d;
    logic                   grant_if;
    logic                   store_full;
    logic                   store_partial;
    logic [ADDR_LENGTH-1:0] rmw_addr;
    logic [WORD_LENGTH-1:0] rmw_wdata;
    logic [WORD_LENGTH-1:0] rmw_old;
    logic [STRB_W-1:0]      rmw_wstrb;
    logic [WORD_LENGTH-1:0] rmw_merged;

    assign store_full    = &d_req_wstrb;
    assign store_partial = ~store_full & (|d_req_wstrb);

`ifdef RISCV_BRAM_ARB_RR_EN
    port_t prio_q;

    // Pick the requester: on contention the priority pointer decides
    always_comb begin
        winner = PORT_IF;
        if (d_req_valid && if_req_valid) begin
            winner = prio_q;
        end else if (d_req_valid) begin
            winner = PORT_D;
        end
    end

    // Flip the pointer away from the winner only after a contended grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= PORT_D;
        end else if (d_req_valid && if_req_valid && state_q == ST_IDLE) begin
            prio_q <= (winner == PORT_D) ? PORT_IF : PORT_D;
        end
    end
`else
    // Fixed priority: D always wins when it is requesting
    always_comb begin
        winner = d_req_valid ? PORT_D : PORT_IF;
    end
`endif

    assign grant_d  = (state_q == ST_IDLE) & d_req_valid  & (winner == PORT_D);
    assign grant_if = (state_q == ST_IDLE) & if_req_valid & (winner == PORT_IF);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a granted partial store spends one extra cycle in RMW
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (grant_d && d_req_we && store_partial) state_d = ST_RMW;
            ST_RMW:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    riscv_bram_byte_merge #(
        .WORD_LENGTH (WORD_LENGTH)
    ) u_merge (
        .old_word (rmw_old),
        .new_word (rmw_wdata),
        .wstrb    (rmw_wstrb),
        .merged   (rmw_merged)
    );

    // FSM outputs: handshakes and BRAM port drive
    always_comb begin
        if_req_ready  = grant_if;
        d_req_ready   = grant_d;
        bram_write_en = 1'b0;
        bram_waddr    = d_req_addr;
        bram_wdata    = d_req_wdata;
        bram_raddr    = grant_d ? d_req_addr : if_req_addr;
        if (state_q == ST_RMW) begin
            bram_write_en = 1'b1;
            bram_waddr    = rmw_addr;
            bram_wdata    = rmw_merged;
            bram_raddr    = rmw_addr;
        end else if (grant_d && d_req_we && store_full) begin
            bram_write_en = 1'b1;
        end
    end

    // Registered responses and the latched read-modify-write context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_valid <= 1'b0;
            if_rsp_rdata <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_rdata  <= '0;
            rmw_addr     <= '0;
            rmw_wdata    <= '0;
            rmw_old      <= '0;
            rmw_wstrb    <= '0;
        end else begin
            if_rsp_valid <= grant_if;
            d_rsp_valid  <= 1'b0;
            if (grant_if) begin
                if_rsp_rdata <= bram_dout;
            end
            if (state_q == ST_RMW) begin
                d_rsp_valid <= 1'b1;
                d_rsp_rdata <= '0;
            end else if (grant_d) begin
                if (d_req_we && store_partial) begin
                    rmw_addr  <= d_req_addr;
                    rmw_wdata <= d_req_wdata;
                    rmw_wstrb <= d_req_wstrb;
                    rmw_old   <= bram_dout;
                end else begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_rdata <= d_req_we ? '0 : bram_dout;
                end
            end
        end
    end

endmodule
